// File: rtl/lab6_pkg.sv
// Shared types and sizing for the writeback register file and its scoreboard.
package lab6_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int PEND_W   = 2;
  localparam int NREGS    = 2 ** ADDR_W;
  localparam int PEND_MAX = 2 ** PEND_W - 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PEND_W-1:0] pend_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback, read-port and issue/stall bundle between the pipeline and the register file.
interface writeback_regfile_if;
  import lab6_pkg::*;

  data_t    wb_data;
  reg_idx_t wb_sel;
  logic     wb_en;
  reg_idx_t rd_sel_a;
  reg_idx_t rd_sel_b;
  data_t    rd_data_a;
  data_t    rd_data_b;
  logic     issue_valid;
  logic     issue_we;
  reg_idx_t issue_dest;
  logic     stall;
  logic     err_underflow;

  modport master (
    output wb_data, wb_sel, wb_en, rd_sel_a, rd_sel_b, issue_valid, issue_we, issue_dest,
    input  rd_data_a, rd_data_b, stall, err_underflow
  );

  modport slave (
    input  wb_data, wb_sel, wb_en, rd_sel_a, rd_sel_b, issue_valid, issue_we, issue_dest,
    output rd_data_a, rd_data_b, stall, err_underflow
  );
endinterface

// File: rtl/pend_counter.sv
// Saturating up/down count of in-flight writes to one architectural register.
module pend_counter
  import lab6_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  dec,
  output pend_t count,
  output logic  is_zero,
  output logic  is_max,
  output logic  underflow
);

  pend_t count_q;
  pend_t count_d;

  // Simultaneous issue and retire cancel; the count never wraps in either direction.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !is_max) begin
      count_d = count_q + pend_t'(1);
    end else if (dec && !inc && !is_zero) begin
      count_d = count_q - pend_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign is_zero   = (count_q == '0);
  assign is_max    = (count_q == pend_t'(PEND_MAX));
  assign underflow = dec && is_zero;

endmodule

// File: rtl/writeback_regfile.sv
// Architectural register file with RAW-hazard scoreboard; define WB_BYPASS_EN for
// same-cycle writeback forwarding to reads and to the stall decision.
module writeback_regfile
  import lab6_pkg::*;
(
  input logic               clk,
  input logic               rst,
  writeback_regfile_if.slave bus
);

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  data_t             regs_q [NREGS];
  data_t             regs_d [NREGS];
  logic              dec;
  logic              inc;
  logic              stall;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  pend_max;
  logic [NREGS-1:1]  pend_zero;
  logic [NREGS-1:1]  pend_uf;
  pend_t             pend_count [1:NREGS-1];
  logic              err_underflow_q;
  logic              err_underflow_d;

  assign dec = bus.wb_en && (bus.wb_sel != REG_ZERO);
  assign inc = bus.issue_valid && bus.issue_we && (bus.issue_dest != REG_ZERO) && !stall;

  // Register 0 never gets a counter, so it can never look busy or saturated.
  assign busy[0]     = 1'b0;
  assign pend_max[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_pend
    logic dec_hit;
    logic inc_hit;

    assign dec_hit = dec && (bus.wb_sel == reg_idx_t'(i));
    assign inc_hit = inc && (bus.issue_dest == reg_idx_t'(i));

    pend_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_hit),
      .dec       (dec_hit),
      .count     (pend_count[i]),
      .is_zero   (pend_zero[i]),
      .is_max    (pend_max[i]),
      .underflow (pend_uf[i])
    );

    // With forwarding, a retire of the last outstanding write clears the hazard this cycle.
    assign busy[i] = !pend_zero[i] && !(BYPASS && dec_hit && (pend_count[i] == pend_t'(1)));
  end

  assign stall = bus.issue_valid &&
                 (busy[bus.rd_sel_a] || busy[bus.rd_sel_b] ||
                  (bus.issue_we && pend_max[bus.issue_dest]));

  always_comb begin
    regs_d = regs_q;
    if (dec) begin
      regs_d[bus.wb_sel] = bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign err_underflow_d = err_underflow_q || (|pend_uf);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow_q <= 1'b0;
    end else begin
      err_underflow_q <= err_underflow_d;
    end
  end

  assign bus.rd_data_a = (BYPASS && dec && (bus.wb_sel == bus.rd_sel_a)) ? bus.wb_data
                                                                        : regs_q[bus.rd_sel_a];
  assign bus.rd_data_b = (BYPASS && dec && (bus.wb_sel == bus.rd_sel_b)) ? bus.wb_data
                                                                        : regs_q[bus.rd_sel_b];
  assign bus.stall         = stall;
  assign bus.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed vector table plus randomized traffic
// against a counting model of the register file and its scoreboard.
module tb_writeback_regfile;
  import lab6_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  writeback_regfile_if bus();

  writeback_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string    tag;
    logic     wb_en;
    int       wb_sel;
    data_t    wb_data;
    int       sel_a;
    int       sel_b;
    logic     iv;
    logic     iwe;
    int       idest;
    data_t    exp_a;
    data_t    exp_b;
    logic     exp_stall;
    logic     exp_err;
  } vec_t;

  vec_t  vecs[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  data_t mem [NREGS];
  int    pend [NREGS];
  bit    err_m;

  function automatic vec_t mk(string tag, logic wb_en, int wb_sel, data_t wb_data,
                              int a, int b, logic iv, logic iwe, int idest,
                              data_t ea, data_t eb, logic es, logic ee);
    vec_t v;
    v.tag = tag; v.wb_en = wb_en; v.wb_sel = wb_sel; v.wb_data = wb_data;
    v.sel_a = a; v.sel_b = b; v.iv = iv; v.iwe = iwe; v.idest = idest;
    v.exp_a = ea; v.exp_b = eb; v.exp_stall = es; v.exp_err = ee;
    return v;
  endfunction

  // Model: values per register, outstanding-write count per register, sticky error bit.
  function automatic bit dec_now();
    return bus.wb_en && (bus.wb_sel != 0);
  endfunction

  function automatic bit busy_m(int i);
    int p;
    if (i == 0) return 1'b0;
    p = pend[i];
    if (BP && dec_now() && int'(bus.wb_sel) == i) p = p - 1;
    return p > 0;
  endfunction

  function automatic bit stall_m();
    return bus.issue_valid &&
           (busy_m(int'(bus.rd_sel_a)) || busy_m(int'(bus.rd_sel_b)) ||
            (bus.issue_we && bus.issue_dest != 0 && pend[int'(bus.issue_dest)] == PEND_MAX));
  endfunction

  function automatic data_t rd_m(int i);
    if (i == 0) return '0;
    if (BP && dec_now() && int'(bus.wb_sel) == i) return bus.wb_data;
    return mem[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mem[i]  = '0;
      pend[i] = 0;
    end
    err_m = 1'b0;
  endtask

  task automatic model_step();
    bit st;
    bit d;
    bit in;
    int np;
    st = stall_m();
    d  = dec_now();
    in = bus.issue_valid && bus.issue_we && bus.issue_dest != 0 && !st;
    if (d) begin
      mem[int'(bus.wb_sel)] = bus.wb_data;
      if (pend[int'(bus.wb_sel)] == 0) err_m = 1'b1;
    end
    for (int i = 1; i < NREGS; i++) begin
      np = pend[i];
      if (in && int'(bus.issue_dest) == i) np = np + 1;
      if (d && int'(bus.wb_sel) == i) np = np - 1;
      pend[i] = (np < 0) ? 0 : np;
    end
  endtask

  task automatic drive(logic wb_en, int wb_sel, data_t wb_data, int a, int b,
                       logic iv, logic iwe, int idest);
    bus.wb_en       = wb_en;
    bus.wb_sel      = reg_idx_t'(wb_sel);
    bus.wb_data     = wb_data;
    bus.rd_sel_a    = reg_idx_t'(a);
    bus.rd_sel_b    = reg_idx_t'(b);
    bus.issue_valid = iv;
    bus.issue_we    = iwe;
    bus.issue_dest  = reg_idx_t'(idest);
  endtask

  task automatic check(string name, data_t act, data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(string tag, data_t ea, data_t eb, logic es, logic ee);
    check({tag, ".rd_a"},  bus.rd_data_a,             ea);
    check({tag, ".rd_b"},  bus.rd_data_b,             eb);
    check({tag, ".stall"}, data_t'(bus.stall),         data_t'(es));
    check({tag, ".err"},   data_t'(bus.err_underflow), data_t'(ee));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cand[$];
    int ws;
    logic we;

    // Directed sequence; expectations are the outputs seen during that cycle.
    vecs.push_back(mk("wr_idx0",    1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_idx0",    0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("iss5",       0, 0, 0,            0, 0, 1, 1, 5, 0, 0, 0, 0));
    vecs.push_back(mk("wb5",        1, 5, 32'h12345678, 5, 0, 0, 0, 0,
                      BP ? 32'h12345678 : 32'h0, 0, 0, 0));
    vecs.push_back(mk("rd5",        0, 0, 0,            5, 0, 0, 0, 0, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk("iss7",       0, 0, 0,            0, 0, 1, 1, 7, 0, 0, 0, 0));
    vecs.push_back(mk("noval7",     0, 0, 0,            0, 7, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("haz7a",      0, 0, 0,            0, 7, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haz7b",      0, 0, 0,            0, 7, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haz7wb",     1, 7, 32'h77,       0, 7, 1, 0, 0,
                      0, BP ? 32'h77 : 32'h0, BP ? 1'b0 : 1'b1, 0));
    vecs.push_back(mk("haz7clr",    0, 0, 0,            0, 7, 1, 0, 0, 0, 32'h77, 0, 0));
    vecs.push_back(mk("iss9a",      0, 0, 0,            0, 0, 1, 1, 9, 0, 0, 0, 0));
    vecs.push_back(mk("iss9b",      0, 0, 0,            0, 0, 1, 1, 9, 0, 0, 0, 0));
    vecs.push_back(mk("iss9c",      0, 0, 0,            0, 0, 1, 1, 9, 0, 0, 0, 0));
    vecs.push_back(mk("sat9",       0, 0, 0,            0, 0, 1, 1, 9, 0, 0, 1, 0));
    vecs.push_back(mk("sat9wb",     1, 9, 32'h90,       0, 0, 1, 1, 9, 0, 0, 1, 0));
    vecs.push_back(mk("iss9ok",     0, 0, 0,            0, 0, 1, 1, 9, 0, 0, 0, 0));
    vecs.push_back(mk("ret9a",      1, 9, 32'h91,       0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ret9b",      1, 9, 32'h92,       0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ret9c",      1, 9, 32'h93,       0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd9",        0, 0, 0,            9, 0, 0, 0, 0, 32'h93, 0, 0, 0));
    vecs.push_back(mk("iss4",       0, 0, 0,            0, 0, 1, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk("iss4wb4",    1, 4, 32'h44,       0, 0, 1, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk("still4",     0, 0, 0,            4, 0, 1, 0, 0, 32'h44, 0, 1, 0));
    vecs.push_back(mk("ret4",       1, 4, 32'h45,       4, 0, 0, 0, 0,
                      BP ? 32'h45 : 32'h44, 0, 0, 0));
    vecs.push_back(mk("uf3",        1, 3, 32'h33,       3, 0, 0, 0, 0,
                      BP ? 32'h33 : 32'h0, 0, 0, 0));
    vecs.push_back(mk("uf3set",     0, 0, 0,            3, 0, 0, 0, 0, 32'h33, 0, 0, 1));
    vecs.push_back(mk("uf3hold",    1, 3, 32'h34,       3, 0, 0, 0, 0,
                      BP ? 32'h34 : 32'h33, 0, 0, 1));
    vecs.push_back(mk("iss12",      0, 0, 0,            3, 0, 1, 1, 12, 32'h34, 0, 0, 1));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    clock_edge();
    clock_edge();
    rst = 1'b0;

    for (int i = 0; i < NREGS; i++) begin
      drive(0, 0, 0, i, NREGS - 1 - i, 0, 0, 0);
      @(negedge clk);
      check_outputs($sformatf("reset_rd%0d", i), 0, 0, 0, 0);
      clock_edge();
    end

    foreach (vecs[k]) begin
      drive(vecs[k].wb_en, vecs[k].wb_sel, vecs[k].wb_data, vecs[k].sel_a, vecs[k].sel_b,
            vecs[k].iv, vecs[k].iwe, vecs[k].idest);
      @(negedge clk);
      check_outputs(vecs[k].tag, vecs[k].exp_a, vecs[k].exp_b, vecs[k].exp_stall,
                    vecs[k].exp_err);
      clock_edge();
    end

    // Reset while a writeback and an issue are in flight, then confirm everything is clear.
    rst = 1'b1;
    drive(1, 3, 32'hAAAA5555, 3, 12, 1, 1, 12);
    clock_edge();
    rst = 1'b0;
    drive(0, 0, 0, 3, 12, 1, 0, 0);
    @(negedge clk);
    check_outputs("post_reset", 0, 0, 0, 0);
    clock_edge();

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        rst = 1'b1;
        drive(1, 1 + int'($urandom_range(6)), $urandom, 1, 2, 1, 1, 3);
        clock_edge();
        rst = 1'b0;
      end
      cand.delete();
      for (int i = 1; i < NREGS; i++) if (pend[i] > 0) cand.push_back(i);
      we = ($urandom_range(1) == 1);
      if (cand.size() > 0 && $urandom_range(15) != 0)
        ws = cand[$urandom_range(cand.size() - 1)];
      else
        ws = int'($urandom_range(NREGS - 1));
      drive(we, ws, $urandom,
            ($urandom_range(3) == 0) ? int'($urandom_range(NREGS - 1)) : int'($urandom_range(7)),
            int'($urandom_range(7)),
            $urandom_range(3) != 0, $urandom_range(3) != 0, int'($urandom_range(7)));
      @(negedge clk);
      check_outputs("rand", rd_m(int'(bus.rd_sel_a)), rd_m(int'(bus.rd_sel_b)),
                    stall_m(), err_m);
      clock_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
